// File: rtl/burst_ram_arbiter.sv
// burst_ram_arbiter
//   Shares one BurstRAM port between the instruction cache (i_*) and the data
//   cache (d_*) with round-robin arbitration. Each cache sees a br_-style port
//   identical to a direct BurstRAM connection. Commands are latched for one
//   cycle and issued downstream when the RAM is free. Read beats are steered to
//   the owning port, and write beats are paced from the owner to the RAM.
//
//   Ports (x = i | d):
//     clk, rst               clock, asynchronous active-high reset
//     x_br_cmd/_cmd_en/_addr command from requester (0=read, 1=write), strobe, address
//     x_br_wr_data/_mask     write beat and byte mask from requester
//     x_br_rd_data/_valid    read beat (broadcast) and owner-only valid
//     x_br_wr_ready          RAM consumes the presented write beat this cycle
//     x_br_busy              command pending or in flight
//     ram_*                  BurstRAM command/data side
//
//   Optional build macro ARB_STATS_EN adds internal grant/wait statistics
//   counters. The port behaviour is unchanged.
module burst_ram_arbiter #(
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_DEPTH_BITWIDTH      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_br_cmd,
  input  logic                                 i_br_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        i_br_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   i_br_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] i_br_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   i_br_rd_data,
  output logic                                 i_br_rd_data_valid,
  output logic                                 i_br_wr_ready,
  output logic                                 i_br_busy,
  input  logic                                 d_br_cmd,
  input  logic                                 d_br_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        d_br_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   d_br_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] d_br_data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   d_br_rd_data,
  output logic                                 d_br_rd_data_valid,
  output logic                                 d_br_wr_ready,
  output logic                                 d_br_busy,
  output logic                                 ram_cmd,
  output logic                                 ram_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        ram_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   ram_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] ram_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   ram_rd_data,
  input  logic                                 ram_rd_data_valid,
  input  logic                                 ram_busy
);

  localparam int CNT_W = (RAM_BURST_DATA_COUNT > 1) ? $clog2(RAM_BURST_DATA_COUNT) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RAM_BURST_DATA_COUNT - 1);
  // Write beat 0 goes out in the grant cycle, so WR only covers beats 1..N-1.
  localparam logic [CNT_W-1:0] WR_LAST =
    CNT_W'((RAM_BURST_DATA_COUNT > 1) ? RAM_BURST_DATA_COUNT - 2 : 0);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_DRAIN} state_t;

  state_t                          state_q, state_d;
  logic                            pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic                            cmd_i_q, cmd_i_d, cmd_d_q, cmd_d_d;
  logic [RAM_DEPTH_BITWIDTH-1:0]   addr_i_q, addr_i_d, addr_d_q, addr_d_d;
  logic                            owner_q, owner_d;  // 0 = I, 1 = D
  logic                            last_q, last_d;    // last granted requester
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            sel;               // owner, or grantee in the grant cycle
  logic                            rd_beat, wr_beat, rel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
      cmd_i_q  <= 1'b0;
      cmd_d_q  <= 1'b0;
      addr_i_q <= '0;
      addr_d_q <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      cmd_i_q  <= cmd_i_d;
      cmd_d_q  <= cmd_d_d;
      addr_i_q <= addr_i_d;
      addr_d_q <= addr_d_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_i_d   = pend_i_q;
    pend_d_d   = pend_d_q;
    cmd_i_d    = cmd_i_q;
    cmd_d_d    = cmd_d_q;
    addr_i_d   = addr_i_q;
    addr_d_d   = addr_d_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    sel        = owner_q;
    rd_beat    = 1'b0;
    wr_beat    = 1'b0;
    rel        = 1'b0;
    ram_cmd_en = 1'b0;
    ram_cmd    = 1'b0;
    ram_addr   = '0;

    case (state_q)
      IDLE: begin
        if ((pend_i_q || pend_d_q) && !ram_busy) begin
          // On a tie, favour the requester that was not granted last.
          sel        = (pend_i_q && pend_d_q) ? ~last_q : pend_d_q;
          ram_cmd_en = 1'b1;
          ram_cmd    = sel ? cmd_d_q : cmd_i_q;
          ram_addr   = sel ? addr_d_q : addr_i_q;
          owner_d    = sel;
          last_d     = sel;
          cnt_d      = '0;
          if (ram_cmd) begin
            wr_beat = 1'b1;
            state_d = (RAM_BURST_DATA_COUNT == 1) ? WR_DRAIN : WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (ram_rd_data_valid) begin
          rd_beat = 1'b1;
          if (cnt_q == RD_LAST) begin
            cnt_d   = '0;
            rel     = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WR: begin
        wr_beat = 1'b1;
        if (cnt_q == WR_LAST) begin
          cnt_d   = '0;
          state_d = WR_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_DRAIN: begin
        if (!ram_busy) begin
          rel     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rel) begin
      if (owner_q) pend_d_d = 1'b0;
      else         pend_i_d = 1'b0;
    end

    // Capture only while not busy. A release and a capture for the same
    // requester can never coincide because release requires pending=1.
    if (i_br_cmd_en && !pend_i_q) begin
      pend_i_d = 1'b1;
      cmd_i_d  = i_br_cmd;
      addr_i_d = i_br_addr;
    end
    if (d_br_cmd_en && !pend_d_q) begin
      pend_d_d = 1'b1;
      cmd_d_d  = d_br_cmd;
      addr_d_d = d_br_addr;
    end
  end

  assign i_br_busy          = pend_i_q;
  assign d_br_busy          = pend_d_q;
  assign i_br_rd_data       = ram_rd_data;
  assign d_br_rd_data       = ram_rd_data;
  assign i_br_rd_data_valid = rd_beat & ~owner_q;
  assign d_br_rd_data_valid = rd_beat & owner_q;
  assign i_br_wr_ready      = wr_beat & ~sel;
  assign d_br_wr_ready      = wr_beat & sel;
  assign ram_wr_data        = wr_beat ? (sel ? d_br_wr_data : i_br_wr_data) : '0;
  assign ram_data_mask      = wr_beat ? (sel ? d_br_data_mask : i_br_data_mask) : '0;

`ifdef ARB_STATS_EN
  logic [63:0] stat_i_grants, stat_d_grants, stat_wait_cycles;
  logic        active;

  assign active = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_i_grants    <= '0;
      stat_d_grants    <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (ram_cmd_en && !sel) stat_i_grants <= stat_i_grants + 64'd1;
      if (ram_cmd_en && sel)  stat_d_grants <= stat_d_grants + 64'd1;
      if ((pend_i_q && !(active && !owner_q)) || (pend_d_q && !(active && owner_q)))
        stat_wait_cycles <= stat_wait_cycles + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Self-checking bench for burst_ram_arbiter: directed steps drive both caches
// and a bench-driven BurstRAM side, and a negedge monitor pops scoreboard queues.
module tb_burst_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_br_cmd, i_br_cmd_en, d_br_cmd, d_br_cmd_en;
  logic [AW-1:0] i_br_addr, d_br_addr;
  logic [DW-1:0] i_br_wr_data, d_br_wr_data;
  logic [MW-1:0] i_br_data_mask, d_br_data_mask;
  logic [DW-1:0] i_br_rd_data, d_br_rd_data;
  logic          i_br_rd_data_valid, d_br_rd_data_valid;
  logic          i_br_wr_ready, d_br_wr_ready, i_br_busy, d_br_busy;
  logic          ram_cmd, ram_cmd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;
  logic [MW-1:0] ram_data_mask;
  logic          ram_rd_data_valid, ram_busy;

  burst_ram_arbiter #(
    .RAM_BURST_DATA_COUNT(4),
    .RAM_BURST_DATA_BITWIDTH(DW),
    .RAM_DEPTH_BITWIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_br_cmd(i_br_cmd), .i_br_cmd_en(i_br_cmd_en), .i_br_addr(i_br_addr),
    .i_br_wr_data(i_br_wr_data), .i_br_data_mask(i_br_data_mask),
    .i_br_rd_data(i_br_rd_data), .i_br_rd_data_valid(i_br_rd_data_valid),
    .i_br_wr_ready(i_br_wr_ready), .i_br_busy(i_br_busy),
    .d_br_cmd(d_br_cmd), .d_br_cmd_en(d_br_cmd_en), .d_br_addr(d_br_addr),
    .d_br_wr_data(d_br_wr_data), .d_br_data_mask(d_br_data_mask),
    .d_br_rd_data(d_br_rd_data), .d_br_rd_data_valid(d_br_rd_data_valid),
    .d_br_wr_ready(d_br_wr_ready), .d_br_busy(d_br_busy),
    .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_data_mask(ram_data_mask),
    .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid),
    .ram_busy(ram_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic cmd; logic [AW-1:0] addr; } cmd_t;
  typedef struct packed { logic owner; logic [DW-1:0] data; logic [MW-1:0] mask; } wr_t;

  cmd_t          exp_cmd[$];
  logic [DW-1:0] exp_i_rd[$];
  logic [DW-1:0] exp_d_rd[$];
  wr_t           exp_wr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Four read beats from the RAM, one per cycle. owner 0/1 = forwarded to I/D.
  task automatic rd_beats(input int owner, input logic [DW-1:0] base);
    for (int k = 0; k < 4; k++) begin
      ram_rd_data       = base + DW'(k);
      ram_rd_data_valid = 1'b1;
      if (owner == 0) exp_i_rd.push_back(base + DW'(k));
      else            exp_d_rd.push_back(base + DW'(k));
      neg();
      chk("owner_busy_in_burst", (owner == 0) ? i_br_busy : d_br_busy, 1'b1);
      step();
    end
    ram_rd_data_valid = 1'b0;
  endtask

  // Scoreboard monitor: every DUT output event pops its expectation.
  always @(negedge clk) begin : mon
    cmd_t          ec;
    wr_t           ew;
    logic [DW-1:0] ed;
    if (ram_cmd_en) begin
      chk("cmd_expected", exp_cmd.size() > 0, 1'b1);
      if (exp_cmd.size() > 0) begin
        ec = exp_cmd.pop_front();
        chk("ram_cmd", ram_cmd, ec.cmd);
        chk("ram_addr", ram_addr, ec.addr);
      end
    end
    if (i_br_rd_data_valid) begin
      chk("i_rd_expected", exp_i_rd.size() > 0, 1'b1);
      if (exp_i_rd.size() > 0) begin
        ed = exp_i_rd.pop_front();
        chk("i_rd_data", i_br_rd_data, ed);
      end
    end
    if (d_br_rd_data_valid) begin
      chk("d_rd_expected", exp_d_rd.size() > 0, 1'b1);
      if (exp_d_rd.size() > 0) begin
        ed = exp_d_rd.pop_front();
        chk("d_rd_data", d_br_rd_data, ed);
      end
    end
    if (i_br_wr_ready || d_br_wr_ready) begin
      chk("wr_ready_both", i_br_wr_ready & d_br_wr_ready, 1'b0);
      chk("wr_expected", exp_wr.size() > 0, 1'b1);
      if (exp_wr.size() > 0) begin
        ew = exp_wr.pop_front();
        chk("wr_owner", d_br_wr_ready, ew.owner);
        chk("ram_wr_data", ram_wr_data, ew.data);
        chk("ram_data_mask", ram_data_mask, ew.mask);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_br_cmd = 1'b0; i_br_cmd_en = 1'b0; i_br_addr = '0; i_br_wr_data = '0; i_br_data_mask = '0;
    d_br_cmd = 1'b0; d_br_cmd_en = 1'b0; d_br_addr = '0; d_br_wr_data = '0; d_br_data_mask = '0;
    ram_rd_data = '0; ram_rd_data_valid = 1'b0; ram_busy = 1'b0;
    step(); step();
    neg();
    chk("rst_busy", {i_br_busy, d_br_busy}, 2'b00);
    chk("rst_rd_valid", {i_br_rd_data_valid, d_br_rd_data_valid}, 2'b00);
    chk("rst_wr_ready", {i_br_wr_ready, d_br_wr_ready}, 2'b00);
    chk("rst_ram_cmd", {ram_cmd_en, ram_cmd, ram_addr}, '0);
    step();
    rst = 1'b0;

    // Single read from I.
    i_br_cmd = 1'b0; i_br_addr = 8'h10; i_br_cmd_en = 1'b1;
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h10});
    neg();
    chk("t1_cmd_en_c0", ram_cmd_en, 1'b0);
    chk("t1_busy_c0", i_br_busy, 1'b0);
    step();
    i_br_cmd_en = 1'b0;
    neg();
    chk("t1_cmd_en_c1", ram_cmd_en, 1'b1);
    chk("t1_busy_c1", i_br_busy, 1'b1);
    step();
    rd_beats(0, 64'h1000);
    neg();
    chk("t1_busy_release", i_br_busy, 1'b0);
    step();

    // Simultaneous reads after reset: D first, then I, then D again on next tie.
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_br_addr = 8'h30; d_br_addr = 8'h40; i_br_cmd = 1'b0; d_br_cmd = 1'b0;
    i_br_cmd_en = 1'b1; d_br_cmd_en = 1'b1;
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h40});
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h30});
    step();
    i_br_cmd_en = 1'b0; d_br_cmd_en = 1'b0;
    neg();
    chk("t2_first_addr", ram_addr, 8'h40);
    step();
    rd_beats(1, 64'h2000);
    neg();
    chk("t2_i_issue_en", ram_cmd_en, 1'b1);
    chk("t2_i_issue_addr", ram_addr, 8'h30);
    step();
    rd_beats(0, 64'h3000);
    i_br_addr = 8'h31; d_br_addr = 8'h41;
    i_br_cmd_en = 1'b1; d_br_cmd_en = 1'b1;
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h41});
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h31});
    step();
    i_br_cmd_en = 1'b0; d_br_cmd_en = 1'b0;
    neg();
    chk("t2_tie2_addr", ram_addr, 8'h41);
    step();
    rd_beats(1, 64'h4000);
    neg();
    chk("t2_tie2_i_addr", {ram_cmd_en, ram_addr}, {1'b1, 8'h31});
    step();
    rd_beats(0, 64'h5000);

    // Write burst from D.
    d_br_cmd = 1'b1; d_br_addr = 8'h20; d_br_cmd_en = 1'b1;
    d_br_wr_data = 64'hA; d_br_data_mask = 8'hFF;
    exp_cmd.push_back('{cmd: 1'b1, addr: 8'h20});
    for (int k = 0; k < 4; k++)
      exp_wr.push_back('{owner: 1'b1, data: 64'hA + DW'(k), mask: 8'hFF});
    step();
    d_br_cmd_en = 1'b0;
    neg();
    chk("t3_cmd_en", ram_cmd_en, 1'b1);
    chk("t3_wr_ready_first", d_br_wr_ready, 1'b1);
    chk("t3_i_wr_ready", i_br_wr_ready, 1'b0);
    step(); d_br_wr_data = 64'hB; ram_busy = 1'b1;
    step(); d_br_wr_data = 64'hC;
    step(); d_br_wr_data = 64'hD;
    step(); d_br_wr_data = 64'h0;
    neg();
    chk("t3_wr_ready_end", d_br_wr_ready, 1'b0);
    chk("t3_busy_drain", d_br_busy, 1'b1);
    step();
    ram_rd_data = 64'hDEAD; ram_rd_data_valid = 1'b1;
    neg();
    chk("t3_stray_beat", d_br_rd_data_valid, 1'b0);
    step();
    ram_rd_data_valid = 1'b0;
    neg();
    chk("t3_busy_ram_busy", d_br_busy, 1'b1);
    step();
    ram_busy = 1'b0;
    neg();
    chk("t3_busy_same_cycle", d_br_busy, 1'b1);
    step();
    neg();
    chk("t3_busy_release", d_br_busy, 1'b0);
    step();

    // Contention: I requests during D's read beat 1.
    d_br_cmd = 1'b0; d_br_addr = 8'h50; d_br_cmd_en = 1'b1;
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h50});
    step();
    d_br_cmd_en = 1'b0;
    neg();
    chk("t4_d_cmd_en", ram_cmd_en, 1'b1);
    step();
    for (int k = 0; k < 4; k++) begin
      ram_rd_data = 64'h6000 + DW'(k); ram_rd_data_valid = 1'b1;
      exp_d_rd.push_back(64'h6000 + DW'(k));
      if (k == 1) begin
        i_br_cmd = 1'b0; i_br_addr = 8'h60; i_br_cmd_en = 1'b1;
        exp_cmd.push_back('{cmd: 1'b0, addr: 8'h60});
      end
      if (k == 2) i_br_cmd_en = 1'b0;
      neg();
      if (k >= 2) chk("t4_i_pending", i_br_busy, 1'b1);
      step();
    end
    ram_rd_data_valid = 1'b0; ram_busy = 1'b1;
    neg();
    chk("t4_hold_ram_busy", ram_cmd_en, 1'b0);
    chk("t4_d_released", {d_br_busy, i_br_busy}, 2'b01);
    step();
    neg();
    chk("t4_hold_ram_busy2", ram_cmd_en, 1'b0);
    step();
    ram_busy = 1'b0;
    neg();
    chk("t4_i_issue", {ram_cmd_en, ram_addr}, {1'b1, 8'h60});
    step();
    rd_beats(0, 64'h7000);

    // Reset in the middle of a read, after beat 1.
    i_br_cmd = 1'b0; i_br_addr = 8'h70; i_br_cmd_en = 1'b1;
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h70});
    step();
    i_br_cmd_en = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      ram_rd_data = 64'h8000 + DW'(k); ram_rd_data_valid = 1'b1;
      exp_i_rd.push_back(64'h8000 + DW'(k));
      step();
    end
    rst = 1'b1;
    ram_rd_data = 64'h8002;
    neg();
    chk("t5_rst_busy", {i_br_busy, d_br_busy}, 2'b00);
    chk("t5_rst_valid", {i_br_rd_data_valid, d_br_rd_data_valid}, 2'b00);
    chk("t5_rst_ram_cmd", {ram_cmd_en, ram_cmd, ram_addr}, '0);
    step();
    rst = 1'b0;
    ram_rd_data = 64'h8003;
    neg();
    chk("t5_late_beat", i_br_rd_data_valid, 1'b0);
    step();
    ram_rd_data_valid = 1'b0;
    i_br_addr = 8'h71; i_br_cmd_en = 1'b1;
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h71});
    step();
    i_br_cmd_en = 1'b0;
    neg();
    chk("t5_next_issue", {ram_cmd_en, ram_addr}, {1'b1, 8'h71});
    step();
    rd_beats(0, 64'h9000);
    neg();
    chk("t5_next_release", i_br_busy, 1'b0);
    step();

    // Command while busy is ignored.
    ram_busy = 1'b1;
    i_br_cmd = 1'b0; i_br_addr = 8'h80; i_br_cmd_en = 1'b1;
    exp_cmd.push_back('{cmd: 1'b0, addr: 8'h80});
    step();
    i_br_cmd = 1'b1; i_br_addr = 8'h90;
    neg();
    chk("t6_busy", i_br_busy, 1'b1);
    chk("t6_no_issue", ram_cmd_en, 1'b0);
    step();
    i_br_cmd_en = 1'b0; ram_busy = 1'b0;
    neg();
    chk("t6_issue", {ram_cmd_en, ram_cmd, ram_addr}, {1'b1, 1'b0, 8'h80});
    step();
    rd_beats(0, 64'hA000);
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("t6_no_second", ram_cmd_en, 1'b0);
      step();
    end
    neg();
    chk("t6_idle", {i_br_busy, d_br_busy}, 2'b00);

    chk("left_cmd", exp_cmd.size(), 0);
    chk("left_i_rd", exp_i_rd.size(), 0);
    chk("left_d_rd", exp_d_rd.size(), 0);
    chk("left_wr", exp_wr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
